// File: rtl/seg7_scan_mux_if.sv
// Display bus between the counter datapath (master) and the 7-segment scan driver (slave).
interface seg7_scan_mux_if #(
  parameter int DIGITS = 6,
  parameter int SEL_W  = 3
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [7:0]          bright;
  logic [SEL_W-1:0]    sel;
  logic [7:0]          seg;
  logic                frame_start;

  modport master (output data_in, dp_in, blank_in, bright,
                  input  sel, seg, frame_start);
  modport slave  (input  data_in, dp_in, blank_in, bright,
                  output sel, seg, frame_start);
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: frame snapshot, per-slot PWM, slot-0 dead time.
// Optional SEG7_LZ_SUPPRESS_EN: blank leading zero digits (dp still shown, last digit always shown).
module seg7_scan_mux #(
  parameter int DIGITS         = 6,
  parameter int SEL_W          = 3,
  parameter int SLOT_CYC       = 8,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic           clk_1khz,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);
  localparam int         SW  = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  generate
    if ((1 << SEL_W) < DIGITS) begin : g_sel_chk
      $error("seg7_scan_mux: SEL_W too small for DIGITS");
    end
    if (SLOT_CYC < 2 || SLOT_CYC > 256 || DIGITS < 2 || DIGITS > 8) begin : g_rng_chk
      $error("seg7_scan_mux: SLOT_CYC or DIGITS out of range");
    end
  endgenerate

  logic [SW-1:0]          slot, slot_nxt;
  logic [SEL_W-1:0]       dig, dig_nxt;
  logic                   snap, slot_wrap;
  logic [DIGITS-1:0][3:0] shd_nib, in_nib, cur_nib;
  logic [DIGITS-1:0]      shd_dp, shd_blank, shd_lz;
  logic [DIGITS-1:0]      in_dp, in_blank, in_lz;
  logic [DIGITS-1:0]      cur_dp, cur_blank, cur_lz;
  logic [7:0]             seg_al;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'h40; 4'h1: dec7 = 7'h79; 4'h2: dec7 = 7'h24; 4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19; 4'h5: dec7 = 7'h12; 4'h6: dec7 = 7'h02; 4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00; 4'h9: dec7 = 7'h10; 4'hA: dec7 = 7'h08; 4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46; 4'hD: dec7 = 7'h21; 4'hE: dec7 = 7'h06; default: dec7 = 7'h0E;
    endcase
  endfunction

  // Re-index the buses by digit: digit 0 sits in the MS nibble/bit, like data_in.
  always_comb begin
    in_nib   = '0;
    in_dp    = '0;
    in_blank = '0;
    for (int i = 0; i < DIGITS; i++) begin
      in_nib[i]   = bus.data_in[4*(DIGITS-1-i) +: 4];
      in_dp[i]    = bus.dp_in[DIGITS-1-i];
      in_blank[i] = bus.blank_in[DIGITS-1-i];
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  always_comb begin
    logic run;
    run   = 1'b1;
    in_lz = '0;
    for (int i = 0; i < DIGITS-1; i++) begin
      run      = run && (in_nib[i] == 4'h0);
      in_lz[i] = run;
    end
  end
`else
  assign in_lz = '0;
`endif

  // Outputs are registered for the next (dig,slot); on the snapshot edge the fresh inputs are used.
  always_comb begin
    snap      = (dig == '0) && (slot == '0);
    slot_wrap = (slot == SW'(SLOT_CYC-1));
    slot_nxt  = slot_wrap ? '0 : slot + 1'b1;
    dig_nxt   = dig;
    if (slot_wrap) dig_nxt = (dig == SEL_W'(DIGITS-1)) ? '0 : dig + 1'b1;
    cur_nib   = snap ? in_nib   : shd_nib;
    cur_dp    = snap ? in_dp    : shd_dp;
    cur_blank = snap ? in_blank : shd_blank;
    cur_lz    = snap ? in_lz    : shd_lz;
    seg_al    = 8'hFF;
    if (slot_nxt != '0 && !cur_blank[dig_nxt] && 9'(slot_nxt) <= {1'b0, bus.bright}) begin
      seg_al[6:0] = cur_lz[dig_nxt] ? 7'h7F : dec7(cur_nib[dig_nxt]);
      seg_al[7]   = ~cur_dp[dig_nxt];
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      slot            <= '0;
      dig             <= '0;
      bus.sel         <= '0;
      bus.seg         <= OFF;
      bus.frame_start <= 1'b0;
      shd_nib         <= '0;
      shd_dp          <= '0;
      shd_blank       <= '0;
      shd_lz          <= '0;
    end else begin
      slot            <= slot_nxt;
      dig             <= dig_nxt;
      bus.sel         <= dig_nxt;
      bus.seg         <= SEG_ACTIVE_LOW ? seg_al : ~seg_al;
      bus.frame_start <= (dig_nxt == '0) && (slot_nxt == '0);
      if (snap) begin
        shd_nib   <= in_nib;
        shd_dp    <= in_dp;
        shd_blank <= in_blank;
        shd_lz    <= in_lz;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: frame-position reference model, directed phases then random inputs.
module tb_seg7_scan_mux;
  localparam int DIGITS   = 6;
  localparam int SLOT_CYC = 8;
  localparam int FRAME    = DIGITS * SLOT_CYC;

  logic clk_1khz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  seg7_scan_mux_if #(.DIGITS(DIGITS), .SEL_W(3)) bus ();

  seg7_scan_mux #(.DIGITS(DIGITS), .SEL_W(3), .SLOT_CYC(SLOT_CYC), .SEG_ACTIVE_LOW(1)) dut (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] dec_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // model: frame position since reset plus the frame's snapshot and the bright seen at the edge
  int         p;
  logic [23:0] m_data;
  logic [5:0]  m_dp, m_blank;
  logic [7:0]  m_br;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s p=%0d got=%0h exp=%0h", tag, p, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int pos);
    int         d = pos / SLOT_CYC;
    int         s = pos % SLOT_CYC;
    logic [7:0] v;
    if (s == 0 || m_blank[DIGITS-1-d] || s > int'(m_br)) return 8'hFF;
    v = dec_t[m_data[4*(DIGITS-1-d) +: 4]];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (d < DIGITS-1 && (m_data >> (4*(DIGITS-1-d))) == 24'h0) v = 8'hFF;
`endif
    if (m_dp[DIGITS-1-d]) v[7] = 1'b0;
    return v;
  endfunction

  task automatic step(input bit rnd);
    if (rnd) begin
      if ($urandom_range(9) == 0) bus.data_in  = 24'($urandom);
      if ($urandom_range(9) == 0) bus.dp_in    = 6'($urandom);
      if ($urandom_range(9) == 0) bus.blank_in = 6'($urandom) & 6'($urandom);
      if ($urandom_range(19) == 0) bus.bright  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(8));
    end
    if (p == 0) begin
      m_data  = bus.data_in;
      m_dp    = bus.dp_in;
      m_blank = bus.blank_in;
    end
    m_br = bus.bright;
    @(posedge clk_1khz);
    p = (p + 1) % FRAME;
    @(negedge clk_1khz);
    chk("sel", 32'(bus.sel), 32'(p / SLOT_CYC));
    chk("seg", 32'(bus.seg), 32'(exp_seg(p)));
    chk("frame_start", 32'(bus.frame_start), 32'(p == 0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(bus.sel), 32'h0);
    chk({tag, "_seg"}, 32'(bus.seg), 32'hFF);
    chk({tag, "_fs"},  32'(bus.frame_start), 32'h0);
  endtask

  initial begin
    bus.data_in  = 24'h123456;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.bright   = 8'd7;
    p = 0; m_data = '0; m_dp = '0; m_blank = '0; m_br = '0;

    #12 chk_reset("rst");
    @(negedge clk_1khz);
    rst_n = 1'b1;

    repeat (2*FRAME) step(0);
    bus.bright = 8'd3;   repeat (FRAME) step(0);
    bus.bright = 8'd0;   repeat (FRAME) step(0);
    bus.bright = 8'd200; repeat (FRAME) step(0);

    // input change mid-frame (digit 2) must wait for the next frame
    bus.bright = 8'd7;
    while (p != 2*SLOT_CYC + 3) step(0);
    bus.data_in = 24'hABCDEF;
    repeat (2*FRAME) step(0);

    bus.data_in  = 24'h123456;
    bus.blank_in = 6'b000001;
    bus.dp_in    = 6'b100000;
    repeat (2*FRAME) step(0);

    // asynchronous reset in the middle of digit 3
    bus.blank_in = '0;
    bus.dp_in    = '0;
    while (p != 3*SLOT_CYC + 5) step(0);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk_1khz);
    chk_reset("rst_held");
    rst_n = 1'b1;
    p = 0; m_data = '0; m_dp = '0; m_blank = '0;
    repeat (FRAME) step(0);

`ifdef SEG7_LZ_SUPPRESS_EN
    while (p != 1) step(0);
    bus.data_in = 24'h000705; repeat (2*FRAME) step(0);
    bus.data_in = 24'h000000; repeat (2*FRAME) step(0);
`endif

    repeat (20*FRAME) step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
